// File: rtl/pipe_stage_chain_pkg.sv
// Shared types for pipe_stage_chain: halt/drain FSM state encodings.
package pipe_stage_chain_pkg;

  typedef enum logic [1:0] {
    PIPE_RUN     = 2'd0,
    PIPE_DRAIN   = 2'd1,
    PIPE_HALTED  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_chain_pipe_reg.sv
// One pipeline latch: payload plus valid bit with load/hold/flush control.
module pipe_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              hold,
  input  logic              flush,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic              valid_next
);

  // Flush beats hold beats load; a stage that is not loaded becomes a bubble.
  always_comb begin
    valid_next = 1'b0;
    if (flush)     valid_next = 1'b0;
    else if (hold) valid_next = q_valid;
    else if (load) valid_next = d_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else begin
      q_valid <= valid_next;
      if (!flush && !hold && load) q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of STAGES valid-tagged pipeline registers with stall/flush, bubbles and halt-drain.
// Optional perf counters built only when PIPE_PERF_CNT_EN is defined.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_ready,
  input  logic [STAGES-1:0]        i_stall,
  input  logic [STAGES-1:0]        i_flush,
  input  logic                     i_out_ready,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [STAGES-1:0]        o_stage_valid,
  output logic [STAGES*DATA_W-1:0] o_stage_data,
  input  logic                     i_halt,
  input  logic                     i_resume,
  output logic                     o_halted,
  output logic [OCC_W-1:0]         o_occupancy,
  output logic [CNT_W-1:0]         o_stall_cycles,
  output logic [CNT_W-1:0]         o_bubble_cycles
);

  pipe_state_t         state_reg;
  logic [STAGES-1:0]   hold;
  logic [STAGES-1:0]   stage_valid;
  logic [STAGES-1:0]   valid_next;
  logic [DATA_W-1:0]   stage_data [STAGES];
  logic [OCC_W-1:0]    occ_next;

  assign o_ready = (state_reg == PIPE_RUN) && !hold[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic              d_valid;
    logic [DATA_W-1:0] d_data;
    logic              load;

    // Hold ripples upstream from the output so bubbles never collapse.
    if (gi == STAGES - 1) begin : g_last
      assign hold[gi] = i_stall[gi] | (stage_valid[gi] & ~i_out_ready);
    end else begin : g_mid
      assign hold[gi] = i_stall[gi] | hold[gi+1];
    end

    if (gi == 0) begin : g_first
      assign d_valid = i_valid;
      assign d_data  = i_data;
      assign load    = o_ready;
    end else begin : g_rest
      assign d_valid = stage_valid[gi-1];
      assign d_data  = stage_data[gi-1];
      assign load    = ~hold[gi-1];
    end

    pipe_reg #(.DATA_W(DATA_W)) u_reg (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .hold       (hold[gi]),
      .flush      (i_flush[gi]),
      .d_valid    (d_valid),
      .d_data     (d_data),
      .q_valid    (stage_valid[gi]),
      .q_data     (stage_data[gi]),
      .valid_next (valid_next[gi])
    );

    assign o_stage_data[gi*DATA_W +: DATA_W] = stage_data[gi];
  end

  assign o_stage_valid = stage_valid;
  assign o_valid       = stage_valid[STAGES-1];
  assign o_data        = stage_data[STAGES-1];

  always_comb begin
    occ_next = '0;
    for (int k = 0; k < STAGES; k++) occ_next = occ_next + OCC_W'(valid_next[k]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= PIPE_RUN;
      o_halted    <= 1'b0;
      o_occupancy <= '0;
    end else begin
      o_occupancy <= occ_next;
      case (state_reg)
        PIPE_RUN: begin
          if (i_halt) state_reg <= PIPE_DRAIN;
        end
        PIPE_DRAIN: begin
          if (valid_next == '0) begin
            state_reg <= PIPE_HALTED;
            o_halted  <= 1'b1;
          end
        end
        PIPE_HALTED: begin
          if (i_resume) begin
            state_reg <= PIPE_RUN;
            o_halted  <= 1'b0;
          end
        end
        default: begin
          state_reg <= PIPE_RUN;
          o_halted  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [STAGES-1:0] bubble_vec;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  bubble_cnt_reg;

  // A bubble enters stage k when it advances while its predecessor is held.
  assign bubble_vec[0] = 1'b0;
  for (genvar gi = 1; gi < STAGES; gi++) begin : g_bubble
    assign bubble_vec[gi] = ~hold[gi] & hold[gi-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (hold[0] && state_reg == PIPE_RUN && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (|bubble_vec && bubble_cnt_reg != '1)
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
    end
  end

  assign o_stall_cycles  = stall_cnt_reg;
  assign o_bubble_cycles = bubble_cnt_reg;
`else
  assign o_stall_cycles  = '0;
  assign o_bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=4, DATA_W=32): stream, stall, freeze, flush, halt, reset.
module tb_pipe_stage_chain;

  localparam int S = 4;
  localparam int W = 32;
  localparam int C = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_valid;
  logic [W-1:0]   i_data;
  logic           o_ready;
  logic [S-1:0]   i_stall;
  logic [S-1:0]   i_flush;
  logic           i_out_ready;
  logic           o_valid;
  logic [W-1:0]   o_data;
  logic [S-1:0]   o_stage_valid;
  logic [S*W-1:0] o_stage_data;
  logic           i_halt;
  logic           i_resume;
  logic           o_halted;
  logic [2:0]     o_occupancy;
  logic [C-1:0]   o_stall_cycles;
  logic [C-1:0]   o_bubble_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_chain #(.STAGES(S), .DATA_W(W), .CNT_W(C)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_valid         (i_valid),
    .i_data          (i_data),
    .o_ready         (o_ready),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .i_out_ready     (i_out_ready),
    .o_valid         (o_valid),
    .o_data          (o_data),
    .o_stage_valid   (o_stage_valid),
    .o_stage_data    (o_stage_data),
    .i_halt          (i_halt),
    .i_resume        (i_resume),
    .o_halted        (o_halted),
    .o_occupancy     (o_occupancy),
    .o_stall_cycles  (o_stall_cycles),
    .o_bubble_cycles (o_bubble_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_data = '0; i_stall = '0; i_flush = '0;
    i_out_ready = 1'b1; i_halt = 1'b0; i_resume = 1'b0;
    tick(); tick();
    chk("rst_valid", o_stage_valid, 4'b0000);
    chk("rst_halted", o_halted, 1'b0);
    chk("rst_occ", o_occupancy, 3'd0);
    chk("rst_stallcnt", o_stall_cycles, 32'd0);
    chk("rst_bubcnt", o_bubble_cycles, 32'd0);
    #2 reset = 1'b0;
    tick();

    // Stream 1..8 with no stalls: item n is at o_data after edge n+3
    for (int n = 1; n <= 8; n++) begin
      i_valid = 1'b1; i_data = n; #1;
      chk("strm_ready", o_ready, 1'b1);
      tick();
      chk("strm_occ", o_occupancy, (n >= 4) ? 3'd4 : 3'(n));
      chk("strm_ovalid", o_valid, n >= 4);
      if (n >= 4) chk("strm_odata", o_data, n - 3);
    end
    // chain now: s3=5 s2=6 s1=7 s0=8

    // One-cycle stall on stage 1
    i_stall = 4'b0010; i_data = 9; #1;
    chk("stall_ready", o_ready, 1'b0);
    tick();
    chk("stall_svalid", o_stage_valid, 4'b1011);
    chk("stall_odata", o_data, 6);
    chk("stall_occ", o_occupancy, 3'd3);
    i_stall = '0; #1;
    chk("unst_ready", o_ready, 1'b1);
    tick();
    chk("bub_svalid", o_stage_valid, 4'b0111);
    chk("bub_ovalid", o_valid, 1'b0);
    i_data = 10;
    tick();
    chk("post_odata", o_data, 7);
    chk("post_svalid", o_stage_valid, 4'b1111);

    // Downstream back-pressure for 3 cycles freezes everything
    i_data = 11; i_out_ready = 1'b0; #1;
    chk("bp_ready", o_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_odata", o_data, 7);
      chk("bp_svalid", o_stage_valid, 4'b1111);
    end
    i_out_ready = 1'b1;
    tick();
    chk("bp_res_odata", o_data, 8);
    i_valid = 1'b0;
    tick();
    chk("bp_next_odata", o_data, 9);
    chk("bp_svalid2", o_stage_valid, 4'b1110);

    // Move 0xAA into stage 2, then flush it while stage 2 is held
    i_valid = 1'b1; i_data = 32'hAA; tick();
    i_data = 32'hBB; tick();
    i_data = 32'hCC; tick();
    chk("fl_s2data", o_stage_data[2*W +: W], 32'hAA);
    chk("fl_svalid0", o_stage_valid, 4'b0111);
    i_valid = 1'b0; i_stall = 4'b0100; i_flush = 4'b0100;
    tick();
    chk("fl_svalid", o_stage_valid, 4'b0011);
    i_stall = '0; i_flush = '0;
    tick();
    chk("fl_ovalid1", o_valid, 1'b0);
    tick();
    chk("fl_odata_bb", o_data, 32'hBB);
    tick();
    chk("fl_odata_cc", o_data, 32'hCC);
    tick();
    chk("fl_empty", o_stage_valid, 4'b0000);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall", o_stall_cycles, 32'd5);
    chk("perf_bubble", o_bubble_cycles, 32'd2);
`endif

    // Halt with three items in flight
    i_valid = 1'b1; i_data = 32'h31; tick();
    i_data = 32'h32; tick();
    i_data = 32'h33; tick();
    i_valid = 1'b0; i_halt = 1'b1;
    tick();
    i_halt = 1'b0; i_valid = 1'b1; i_data = 32'h99; #1;
    chk("halt_ready", o_ready, 1'b0);
    chk("halt_odata1", o_data, 32'h31);
    chk("halt_notyet", o_halted, 1'b0);
    tick();
    chk("halt_odata2", o_data, 32'h32);
    chk("halt_occ2", o_occupancy, 3'd2);
    tick();
    chk("halt_odata3", o_data, 32'h33);
    chk("halt_dr_halted", o_halted, 1'b0);
    tick();
    chk("halted", o_halted, 1'b1);
    chk("halt_occ0", o_occupancy, 3'd0);
    chk("halt_ready2", o_ready, 1'b0);
    i_valid = 1'b0; i_halt = 1'b1; i_resume = 1'b1;
    tick();
    i_halt = 1'b0; i_resume = 1'b0; #1;
    chk("res_halted", o_halted, 1'b0);
    chk("res_ready", o_ready, 1'b1);

    // Asynchronous reset while draining
    i_valid = 1'b1; i_data = 32'h41; tick();
    i_valid = 1'b0; i_halt = 1'b1; tick();
    i_halt = 1'b0; #1;
    chk("dr_ready", o_ready, 1'b0);
    chk("dr_occ", o_occupancy, 3'd1);
    reset = 1'b1; #1;
    chk("arst_svalid", o_stage_valid, 4'b0000);
    chk("arst_occ", o_occupancy, 3'd0);
    chk("arst_halted", o_halted, 1'b0);
    chk("arst_ready", o_ready, 1'b1);
    chk("arst_stall", o_stall_cycles, 32'd0);
    chk("arst_bubble", o_bubble_cycles, 32'd0);
    #2 reset = 1'b0;
    tick();
    chk("post_rst_valid", o_stage_valid, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
